// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - operand fetch and diagonal skew stage for the 4x4 systolic array
module systolic_feeder #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [AW-1:0]   k_len,
    input  logic [AW-1:0]   a_base,
    input  logic [AW-1:0]   b_base,
    output logic            a_rd_en,
    output logic [AW-1:0]   a_addr,
    input  logic [N*DW-1:0] a_rdata,
    output logic            b_rd_en,
    output logic [AW-1:0]   b_addr,
    input  logic [N*DW-1:0] b_rdata,
    output logic [N*DW-1:0] in_a,
    output logic [N*DW-1:0] in_b,
    output logic            acc_clr,
    output logic            busy,
    output logic            done
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    // skew flush (N-1) + array propagation (N-1) + read and output registers (2)
    localparam logic [AW-1:0] DRAIN_LAST = AW'(2*N - 1);

    state_t          state, state_nx;
    logic [AW-1:0]   cnt, k_q, a_base_q, b_base_q;
    logic            rd_q;
    logic [N*DW-1:0] a_word_q, b_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            k_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            acc_clr  <= 1'b0;
            rd_q     <= 1'b0;
            a_word_q <= '0;
            b_word_q <= '0;
        end else begin
            state <= state_nx;
            if (state != state_nx)
                cnt <= '0;
            else if (state == FETCH || state == DRAIN)
                cnt <= cnt + 1'b1;
            if (state == IDLE && state_nx == FETCH) begin
                k_q      <= k_len;
                a_base_q <= a_base;
                b_base_q <= b_base;
            end
            acc_clr  <= (state == IDLE && state_nx == FETCH);
            // only words that were actually requested enter the skew; everything else is zero fill
            rd_q     <= a_rd_en;
            a_word_q <= rd_q ? a_rdata : '0;
            b_word_q <= rd_q ? b_rdata : '0;
        end
    end

    always_comb begin
        state_nx = state;
        a_rd_en  = 1'b0;
        b_rd_en  = 1'b0;
        a_addr   = '0;
        b_addr   = '0;
        busy     = (state != IDLE);
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start && k_len != '0)
                    state_nx = FETCH;
            end
            FETCH: begin
                a_rd_en = 1'b1;
                b_rd_en = 1'b1;
                a_addr  = a_base_q + cnt;
                b_addr  = b_base_q + cnt;
                if (cnt == k_q - 1'b1)
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == DRAIN_LAST)
                    state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        localparam int HI = N*DW - 1 - j*DW;
        if (j == 0) begin : g_direct
            assign in_a[HI -: DW] = a_word_q[HI -: DW];
            assign in_b[HI -: DW] = b_word_q[HI -: DW];
        end else begin : g_delay
            logic [DW-1:0] a_sr [j];
            logic [DW-1:0] b_sr [j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s < j; s++) begin
                        a_sr[s] <= '0;
                        b_sr[s] <= '0;
                    end
                end else begin
                    a_sr[0] <= a_word_q[HI -: DW];
                    b_sr[0] <= b_word_q[HI -: DW];
                    for (int s = 1; s < j; s++) begin
                        a_sr[s] <= a_sr[s-1];
                        b_sr[s] <= b_sr[s-1];
                    end
                end
            end
            assign in_a[HI -: DW] = a_sr[j-1];
            assign in_b[HI -: DW] = b_sr[j-1];
        end
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Upstream operand stage for the 4x4 int8 systolic_array.
- On start, reads K consecutive 32-bit words of A (column slices) and B (row slices) from two synchronous-read operand buffers.
- Applies the diagonal skew (lane j delayed j cycles) and drives the array's in_a/in_b buses, zero-padding around the skewed wavefront.
- Sequences fetch, skew drain and array propagation, then pulses done.

Parameters:
- N, 4, array dimension (lanes per operand bus).
- DW, 8, operand byte width.
- AW, 8, operand buffer address width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request pulse; sampled only when busy=0.
- k_len  input  AW  number of K steps (words per operand); 0 means ignore start.
- a_base  input  AW  A buffer start address; latched on accepted start.
- b_base  input  AW  B buffer start address; latched on accepted start.
- a_rd_en  output  1  A buffer read strobe.
- a_addr  output  AW  A buffer read address.
- a_rdata  input  N*DW  A word; valid the cycle after a_rd_en.
- b_rd_en  output  1  B buffer read strobe.
- b_addr  output  AW  B buffer read address.
- b_rdata  input  N*DW  B word; valid the cycle after b_rd_en.
- in_a  output  N*DW  to systolic_array in_a; lane 0 = [N*DW-1 -: DW].
- in_b  output  N*DW  to systolic_array in_b; lane 0 = [N*DW-1 -: DW].
- acc_clr  output  1  one-cycle pulse telling the consumer to clear accumulators.
- busy  output  1  operation in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, counters 0, all skew registers 0.
- States:
  - IDLE: entered from reset or after DONE.
  - FETCH: k_len cycles.
  - DRAIN: 2N cycles.
  - DONE: 1 cycle.
- IDLE -> FETCH on start=1 && k_len!=0 at edge E0. This latches k_len, a_base and b_base. acc_clr=1 and busy=1 in the cycle after E0.
- start while busy, or with k_len=0, is ignored: no state change and no pulse.
- FETCH:
  - a_rd_en = b_rd_en = 1 each cycle.
  - In FETCH cycle t (t=0..k_len-1): a_addr = a_base+t and b_addr = b_base+t, both mod 2^AW (wrap permitted).
  - After the k_len-th read, go to DRAIN.
  - Outside FETCH: rd_en=0 and addr=0.
- Data path:
  - Returned word is registered once. Then lane j passes through j further register stages.
  - Word fetched in FETCH cycle t appears on lane j of in_a/in_b in cycle t+2+j, where cycle 0 is the first FETCH cycle.
  - Lanes carry 0 whenever no valid element occupies that slot (pre-fill, gaps, drain).
- DRAIN: no reads; skew pipeline keeps shifting zeros in. Lasts 2N cycles: N-1 for skew flush plus N-1 for array propagation, plus 2 for read/output registers. Then go to DONE.
- DONE: done=1 and busy=1 for exactly that cycle. Next cycle: IDLE, busy=0, and start is acceptable again.
- Timing for N=4, with last FETCH cycle L:
  - Last non-zero lane-3 byte at L+5.
  - done in cycle L+9.
  - busy high from E0+1 through L+9 inclusive.
  - Total busy cycles = k_len+9.
- Back-to-back: a start asserted in the DONE cycle is ignored. A start in the first IDLE cycle is accepted.
- rst asserted mid-operation: immediate return to IDLE, all outputs 0, skew contents discarded, no done pulse.
- No arithmetic beyond address increment; operand bytes pass unmodified.

Test Plan:
- Reset, then idle 5 cycles -> in_a=in_b=0, busy=done=acc_clr=a_rd_en=b_rd_en=0 throughout.
- k_len=1, a_base=0x10, A[0x10]=0x01020304 -> acc_clr at E0+1; in_a lanes 0..3 = 0x01,0x02,0x03,0x04 in cycles 2,3,4,5 (zero elsewhere); done at cycle 9; busy 10 cycles.
- k_len=4, A=identity columns, B=ramp 1..16 -> captured in_a/in_b waveforms match the golden skewed diagonal. The array's row-0 out_c equals A×B row 0.
- a_base=0xFE, k_len=4 -> a_addr sequence 0xFE,0xFF,0x00,0x01.
- start held high through an operation, plus a k_len=0 start in IDLE -> exactly one operation, one done; the k_len=0 start produces no busy.
- rst pulsed in FETCH cycle 2 -> all outputs 0 within the reset cycle, no done. A subsequent start runs normally with correct timing.
